unary_add_seq: RTL and testbench

Sequencer for the mod-13 unary accumulator (the `Unary_add_*` family). It accepts binary operand pairs over a valid/ready request port and serialises each operand into a unary bit stream on the accumulator's A/B inputs. It then drains the accumulator in write mode, re-counts the dout pulses into a binary sum, and returns sum plus wrap carry over a valid/ready response port. It sits between the host register interface and one accumulator instance, and is the accumulator's only driver.

---
 rtl/unary_add_seq_if.sv | 37 +++
 rtl/unary_add_seq.sv | 132 +++++++++++++
 tb/tb_unary_add_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/unary_add_seq_if.sv
// Bus bundle for unary_add_seq: host request/response handshakes plus the accumulator drive lines.
// The sequencer uses the slave modport; the environment (host + accumulator) uses master.
interface unary_add_seq_if #(
  parameter int unsigned W = 4
) ();
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry;
  logic         rsp_err;

  logic         add_en;
  logic         add_rw;
  logic         add_a;
  logic         add_b;
  logic         add_dout;
  logic         add_c;

  logic         busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_dout, add_c,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err,
    input  add_en, add_rw, add_a, add_b, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_dout, add_c,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err,
    output add_en, add_rw, add_a, add_b, busy
  );
endinterface

// File: rtl/unary_add_seq.sv
// Sequencer for a mod-MOD unary accumulator: feeds binary operands as unary streams,
// drains the accumulator and re-counts the pulses into a binary sum with wrap carry.
module unary_add_seq #(
  parameter int unsigned MOD = 13,
  parameter int unsigned W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  unary_add_seq_if.slave bus_io
);

  localparam int unsigned DW = $clog2(MOD + 2);
  localparam logic [W-1:0]  SumMax    = W'(MOD - 1);
  localparam logic [DW-1:0] DrainLast = DW'(MOD + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StResp} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  ra_q, ra_d;
  logic [W-1:0]  rb_q, rb_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          op_bad;

  // Widened compare so MOD == 2^W does not wrap the bound.
  assign op_bad = ({1'b0, bus_io.req_a} >= (W + 1)'(MOD)) ||
                  ({1'b0, bus_io.req_b} >= (W + 1)'(MOD));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    dcnt_d  = dcnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          ra_d    = bus_io.req_a;
          rb_d    = bus_io.req_b;
          sum_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          dcnt_d  = '0;
          if (op_bad) begin
            ra_d    = '0;
            rb_d    = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else if (bus_io.req_a == '0 && bus_io.req_b == '0) begin
            state_d = StDrain;
          end else begin
            state_d = StFeed;
          end
        end
      end

      StFeed: begin
        if (ra_q != '0) ra_d = ra_q - W'(1);
        if (rb_q != '0) rb_d = rb_q - W'(1);
        carry_d = carry_q | bus_io.add_c;
        if (ra_d == '0 && rb_d == '0) begin
          dcnt_d  = '0;
          state_d = StDrain;
        end
      end

      StDrain: begin
        // First drain cycle only shows the carry from the last feed edge; dout is still stale.
        if (dcnt_q == '0) begin
          carry_d = carry_q | bus_io.add_c;
        end else if (bus_io.add_dout && sum_q != SumMax) begin
          sum_d = sum_q + W'(1);
        end

        if (dcnt_q != '0 && !bus_io.add_dout) begin
          state_d = StResp;
        end else if (dcnt_q == DrainLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      StResp: begin
        if (bus_io.rsp_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    bus_io.req_ready = (state_q == StIdle);
    bus_io.busy      = (state_q != StIdle);
    bus_io.add_en    = (state_q == StFeed) || (state_q == StDrain);
    bus_io.add_rw    = (state_q == StDrain);
    bus_io.add_a     = (state_q == StFeed) && (ra_q != '0);
    bus_io.add_b     = (state_q == StFeed) && (rb_q != '0);
    bus_io.rsp_valid = (state_q == StResp);
    bus_io.rsp_sum   = (state_q == StResp) ? sum_q : '0;
    bus_io.rsp_carry = (state_q == StResp) && carry_q;
    bus_io.rsp_err   = (state_q == StResp) && err_q;
  end

endmodule

// File: tb/tb_unary_add_seq.sv
// Directed bench for unary_add_seq with a behavioural mod-13 unary accumulator attached.
module tb_unary_add_seq;

  localparam int MOD = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unary_add_seq_if #(.W(4)) bus ();

  unary_add_seq #(.MOD(13), .W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Accumulator model: registered count, registered drain pulse, one-cycle wrap carry.
  int   acc_cnt;
  logic acc_dout;
  logic acc_c;
  logic stuck_dout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= 0;
      acc_dout <= 1'b0;
      acc_c    <= 1'b0;
    end else if (bus.add_en && !bus.add_rw) begin
      acc_dout <= 1'b0;
      if (acc_cnt + int'(bus.add_a) + int'(bus.add_b) >= MOD) begin
        acc_cnt <= acc_cnt + int'(bus.add_a) + int'(bus.add_b) - MOD;
        acc_c   <= 1'b1;
      end else begin
        acc_cnt <= acc_cnt + int'(bus.add_a) + int'(bus.add_b);
        acc_c   <= 1'b0;
      end
    end else if (bus.add_en && bus.add_rw) begin
      acc_c <= 1'b0;
      if (acc_cnt != 0) begin
        acc_dout <= 1'b1;
        acc_cnt  <= acc_cnt - 1;
      end else begin
        acc_dout <= 1'b0;
      end
    end else begin
      acc_dout <= 1'b0;
      acc_c    <= 1'b0;
    end
  end

  assign bus.add_dout = acc_dout | stuck_dout;
  assign bus.add_c    = acc_c;

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.req_ready, bus.busy, bus.add_en, bus.add_rw, bus.add_a, bus.add_b,
                 bus.rsp_valid, bus.rsp_err, bus.rsp_carry, bus.rsp_sum});
  endfunction

  localparam int ResetOuts = 32'h1000;

  // Called at a negedge with the request already driven; the next posedge is the accept edge.
  task automatic collect(input bit nv, input logic [3:0] na, input logic [3:0] nb,
                         output int lat, output int en_c, output int a_c, output int b_c);
    lat = -1; en_c = 0; a_c = 0; b_c = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = nv;
        bus.req_a     = na;
        bus.req_b     = nb;
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      en_c += int'(bus.add_en);
      a_c  += int'(bus.add_a);
      b_c  += int'(bus.add_b);
    end
  endtask

  task automatic handshake(input string name);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({name, " idle_after"}, int'({bus.req_ready, bus.busy}), 2);
  endtask

  task automatic run_vec(input string name, input int a, input int b, input int es,
                         input int ec, input int ee, input int elat);
    int lat, en_c, a_c, b_c;
    bus.req_valid = 1'b1;
    bus.req_a     = 4'(a);
    bus.req_b     = 4'(b);
    collect(1'b0, 4'd0, 4'd0, lat, en_c, a_c, b_c);
    chk({name, " latency"}, lat, elat);
    chk({name, " sum"}, int'(bus.rsp_sum), es);
    chk({name, " carry"}, int'(bus.rsp_carry), ec);
    chk({name, " err"}, int'(bus.rsp_err), ee);
    chk({name, " en_cycles"}, en_c, elat - 1);
    chk({name, " a_pulses"}, a_c, (elat == 1) ? 0 : a);
    chk({name, " b_pulses"}, b_c, (elat == 1) ? 0 : b);
    handshake(name);
  endtask

  typedef struct {
    string name;
    int a, b, sum, carry, err, lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, en_c, a_c, b_c, seen;

    vecs[0] = '{"basic_3_2",   3,  2,  5, 0, 0, 11};
    vecs[1] = '{"wrap_7_6",    7,  6,  0, 1, 0, 10};
    vecs[2] = '{"zero_0_0",    0,  0,  0, 0, 0,  3};
    vecs[3] = '{"max_12_12",  12, 12, 11, 1, 0, 26};
    vecs[4] = '{"after_max",   1,  0,  1, 0, 0,  5};
    vecs[5] = '{"range_13_0", 13,  0,  0, 0, 1,  1};
    vecs[6] = '{"nowrap_0_12", 0, 12, 12, 0, 0, 27};
    vecs[7] = '{"wrap_5_9",    5,  9,  1, 1, 0, 13};
    vecs[8] = '{"range_15_3", 15,  3,  0, 0, 1,  1};
    vecs[9] = '{"single_10_0",10,  0, 10, 0, 0, 23};

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    #1;
    chk("reset_outputs", outs(), ResetOuts);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", outs(), ResetOuts);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry,
              vecs[i].err, vecs[i].lat);
    end

    // Response backpressure with a second request held on the port.
    bus.req_valid = 1'b1;
    bus.req_a     = 4'd4;
    bus.req_b     = 4'd3;
    collect(1'b1, 4'd1, 4'd1, lat, en_c, a_c, b_c);
    chk("bp latency", lat, 14);
    chk("bp sum", int'(bus.rsp_sum), 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold", int'({bus.rsp_valid, bus.rsp_err, bus.rsp_carry, bus.rsp_sum,
                           bus.req_ready}), int'({1'b1, 1'b0, 1'b0, 4'd7, 1'b0}));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp idle_ready", int'(bus.req_ready), 1);
    collect(1'b0, 4'd0, 4'd0, lat, en_c, a_c, b_c);
    chk("bp second latency", lat, 6);
    chk("bp second sum", int'(bus.rsp_sum), 2);
    handshake("bp second");

    // Reset asserted in cycle 4 of a FEED.
    bus.req_valid = 1'b1;
    bus.req_a     = 4'd9;
    bus.req_b     = 4'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midfeed busy", int'(bus.add_en), 1);
    rst_n = 1'b0;
    #1;
    chk("midfeed reset_outputs", outs(), ResetOuts);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(bus.rsp_valid);
    end
    chk("midfeed no_response", seen, 0);
    run_vec("after_reset_2_2", 2, 2, 4, 0, 0, 9);

    // Accumulator dout stuck high: drain must time out with a saturated partial sum.
    stuck_dout = 1'b1;
    run_vec("timeout_1_0", 1, 0, 12, 0, 1, 17);
    stuck_dout = 1'b0;
    run_vec("after_timeout", 2, 3, 5, 0, 0, 11);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
